instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Byte-stream program loader: the write side of the 256x8 instruction memory that the fetch path reads by PC address. It accepts a framed byte stream over a valid/ready handshake, writes the payload into instruction memory through a dedicated write port, and holds the CPU while a load is in progress. Sits between the host/debug link and the instruction memory write port. Its cpu_hold output feeds the PC/control stall logic.

Parameters:
ADDR_W, 8, instruction memory address width (256 locations)
DATA_W, 8, instruction word width
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 1000, max idle cycles between bytes inside a frame before abort

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rx_valid  input  1  rx_data holds a byte
rx_data  input  8  stream byte
rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid & rx_ready at a rising edge
mem_we  output  1  instruction memory write enable, one cycle per payload byte
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
cpu_hold  output  1  stall PC/fetch while high
busy  output  1  frame in progress (state != IDLE)
load_done  output  1  one-cycle pulse on a successful frame
load_err  output  1  sticky error flag; cleared on the next SYNC accept

Behaviour:
- Frame format: SYNC_BYTE, START_ADDR, LEN, LEN payload bytes, CHK. LEN=0 means 256 bytes; the payload counter is 9 bits. CHK = 8-bit modulo sum of the payload bytes only.
- States: IDLE -> ADDR -> LEN -> DATA -> CHK -> FINISH -> IDLE.
  - IDLE: non-SYNC bytes are accepted and discarded. A SYNC byte moves to ADDR, sets cpu_hold=1, clears load_err.
  - ADDR: latch write pointer.
  - LEN: latch count, clear running sum.
  - DATA: each accepted byte registers mem_we=1, mem_addr=pointer, mem_wdata=byte in the cycle after acceptance. Pointer increments modulo 256 (0xFF wraps to 0x00). Sum accumulates. After the last byte, go to CHK.
  - CHK: compare the byte with the sum, then go to FINISH.
  - FINISH: lasts one cycle with rx_ready=0. On match: load_done=1 for this cycle and cpu_hold=0 from the next cycle. On mismatch: load_err=1 and cpu_hold stays 1.
- cpu_hold, once set by an error or timeout, stays high until a later frame completes successfully. Payload bytes written before an error are not rolled back.
- rx_ready=1 in every state except FINISH and while reset is asserted. Back-to-back bytes every cycle are supported.
- Timeout: an idle counter runs in ADDR, LEN, DATA and CHK. It clears on each accepted byte. When it reaches TIMEOUT, the frame is aborted: load_err=1, cpu_hold stays 1, state returns to IDLE, and no mem_we is issued.
- SYNC_BYTE inside ADDR, LEN, DATA or CHK is treated as ordinary data (no resync).
- Reset values: state=IDLE, rx_ready=0 during reset, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, load_done=0, load_err=0, counters=0.
- Reset asserted mid-frame aborts immediately to these values. No write is issued after reset asserts.
- Latency: payload byte to mem_we is 1 cycle. CHK byte to load_done/load_err is 1 cycle.

Test Plan:
- Basic load: stream A5 10 03 11 22 33 66 at one byte per cycle -> writes [0x10]=11, [0x11]=22, [0x12]=33 on consecutive cycles; load_done pulses once; cpu_hold high from the cycle after A5 until the cycle after FINISH.
- Wrap: A5 FE 03 01 02 03 06 -> writes addresses FE, FF, 00 with data 01, 02, 03; load_done=1; load_err=0.
- Bad checksum: A5 00 01 7F 00 -> [0x00]=7F written; load_err=1; load_done=0; cpu_hold stays 1. A following good frame A5 00 01 7F 7F -> load_err clears on A5, load_done pulses, cpu_hold returns to 0.
- Garbage, gaps and timeout: 00 FF 3C then A5 20 02 AA with rx_valid toggling -> leading bytes ignored with no writes. A stall of TIMEOUT=1000 cycles after AA -> load_err=1, state IDLE, no further mem_we.
- LEN=0: A5 00 00 followed by 256 bytes 0x01 and CHK 00 -> 256 writes covering 00..FF; load_done=1.
- Reset mid-frame: reset asserted after the second payload byte of the basic frame -> all outputs return to reset values asynchronously; no third write; next frame loads normally.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: parses SYNC/ADDR/LEN/payload/CHK frames and drives the
// instruction memory write port, holding the CPU while a load is in flight.
module instr_mem_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  // A byte moves when rx_valid & rx_ready at a rising clk edge; rx_valid may toggle freely.
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [8:0]          rem_q, rem_d;
  logic [7:0]          sum_q, sum_d;
  logic [CNT_W-1:0]    idle_q, idle_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic accept;
  logic in_frame;
  logic timeout_hit;

  assign rx_ready    = !reset && (state_q != S_FINISH);
  assign accept      = rx_valid && rx_ready;
  assign in_frame    = (state_q == S_ADDR) || (state_q == S_LEN) ||
                       (state_q == S_DATA) || (state_q == S_CHK);
  // Abort on the TIMEOUT-th consecutive idle cycle inside a frame.
  assign timeout_hit = in_frame && !accept && (idle_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && rx_data == SYNC_BYTE) state_d = S_ADDR;
      S_ADDR:   if (accept) state_d = S_LEN;
      S_LEN:    if (accept) state_d = S_DATA;
      S_DATA:   if (accept && rem_q == 9'd1) state_d = S_CHK;
      S_CHK:    if (accept) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_IDLE;
  end

  always_comb begin
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    idle_d  = (in_frame && !accept) ? idle_q + CNT_W'(1) : '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (accept && rx_data == SYNC_BYTE) begin
        hold_d = 1'b1;
        err_d  = 1'b0;
      end
      S_ADDR: if (accept) ptr_d = ADDR_W'(rx_data);
      S_LEN: if (accept) begin
        // LEN of zero encodes a full 256-byte payload.
        rem_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        sum_d = 8'd0;
      end
      S_DATA: if (accept) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = DATA_W'(rx_data);
        ptr_d   = ptr_q + ADDR_W'(1);
        sum_d   = sum_q + rx_data;
        rem_d   = rem_q - 9'd1;
      end
      S_CHK: if (accept) begin
        if (rx_data == sum_q) done_d = 1'b1;
        else                  err_d  = 1'b1;
      end
      S_FINISH: if (done_q) hold_d = 1'b0;
      default: ;
    endcase
    if (timeout_hit) begin
      err_d  = 1'b1;
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: table of frames plus hand-written sequences for
// garbage/timeout and mid-frame reset; writes are scoreboarded through a queue.
module tb_instr_mem_loader;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       load_done;
  logic       load_err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];

  instr_mem_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write the DUT issues must match the head of exp_q.
  always @(negedge clk) begin
    if (!reset && load_done) done_cnt++;
    if (!reset && mem_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          fails++;
          $display("FAIL write: got %0h expected %0h", {mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] start;
    int         len;
    logic [7:0] seed;
    logic [7:0] step;
    logic [7:0] chk_xor;
    int         max_gap;
  } frame_t;

  task automatic send_frame(input frame_t f);
    logic [7:0] addr, d, sum, len_enc;
    logic good;
    int base;
    good    = (f.chk_xor == 8'h00);
    addr    = f.start;
    sum     = 8'h00;
    len_enc = (f.len == 256) ? 8'h00 : 8'(f.len);
    send_byte(SYNC, $urandom_range(0, f.max_gap));
    check("sync_hold", 32'(cpu_hold), 32'd1);
    check("sync_err_clear", 32'(load_err), 32'd0);
    check("sync_busy", 32'(busy), 32'd1);
    send_byte(f.start, $urandom_range(0, f.max_gap));
    send_byte(len_enc, $urandom_range(0, f.max_gap));
    for (int i = 0; i < f.len; i++) begin
      d = f.seed + 8'(f.step * i);
      exp_q.push_back({addr, d});
      sum  = sum + d;
      addr = addr + 8'd1;
      send_byte(d, $urandom_range(0, f.max_gap));
    end
    base = done_cnt;
    send_byte(sum ^ f.chk_xor, $urandom_range(0, f.max_gap));
    check("finish_ready", 32'(rx_ready), 32'd0);
    check("finish_done", 32'(load_done), 32'(good));
    check("finish_err", 32'(load_err), 32'(!good));
    check("finish_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    #1;
    check("done_pulses", 32'(done_cnt - base), 32'(good));
    check("after_hold", 32'(cpu_hold), 32'(!good));
    check("after_busy", 32'(busy), 32'd0);
    check("after_err", 32'(load_err), 32'(!good));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  frame_t frames[6];

  initial begin
    frames[0] = '{start: 8'h10, len: 3,   seed: 8'h11, step: 8'h11, chk_xor: 8'h00, max_gap: 0};
    frames[1] = '{start: 8'hFE, len: 3,   seed: 8'h01, step: 8'h01, chk_xor: 8'h00, max_gap: 0};
    frames[2] = '{start: 8'h00, len: 1,   seed: 8'h7F, step: 8'h00, chk_xor: 8'h7F, max_gap: 0};
    frames[3] = '{start: 8'h00, len: 1,   seed: 8'h7F, step: 8'h00, chk_xor: 8'h00, max_gap: 0};
    frames[4] = '{start: 8'h00, len: 256, seed: 8'h01, step: 8'h00, chk_xor: 8'h00, max_gap: 0};
    frames[5] = '{start: 8'h40, len: 5,   seed: 8'hA5, step: 8'h00, chk_xor: 8'h00, max_gap: 3};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) send_frame(frames[i]);

    // Garbage in IDLE, then a frame with gaps that stalls into the timeout.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h3C, 2);
    check("garbage_busy", 32'(busy), 32'd0);
    check("garbage_hold", 32'(cpu_hold), 32'd0);
    send_byte(SYNC, 1);
    send_byte(8'h20, 2);
    send_byte(8'h02, 1);
    exp_q.push_back({8'h20, 8'hAA});
    send_byte(8'hAA, 3);
    repeat (TIMEOUT - 10) @(negedge clk);
    check("pre_timeout_busy", 32'(busy), 32'd1);
    check("pre_timeout_err", 32'(load_err), 32'd0);
    repeat (20) @(negedge clk);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_err", 32'(load_err), 32'd1);
    check("timeout_hold", 32'(cpu_hold), 32'd1);
    check("timeout_queue", 32'(exp_q.size()), 32'd0);

    // Reset after the second payload byte of the basic frame.
    send_byte(SYNC, 0);
    send_byte(8'h10, 0);
    send_byte(8'h03, 0);
    exp_q.push_back({8'h10, 8'h11});
    send_byte(8'h11, 0);
    exp_q.push_back({8'h11, 8'h22});
    send_byte(8'h22, 0);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    check("midreset_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(frames[0]);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
